debug_uart_tx_arbiter: RTL

DEBUG_UART_TX_ARBITER -- requirements
Module: debug_uart_tx_arbiter

---
 rtl/debug_uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_bit_tick.sv | 34 +++
 rtl/debug_uart_tx_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/debug_uart_tx_arbiter_pkg.sv
// rtl/debug_uart_tx_arbiter_pkg.sv - shared states and default timing constants
// for the debug UART TX ownership arbiter.
package debug_uart_tx_arbiter_pkg;

  localparam int MCU_MAIN_CLK_RATE = 48_000_000;
  localparam int DEBUG_UART_BAUD   = 115_200;
  localparam int DEF_BAUD_PERIOD   = MCU_MAIN_CLK_RATE / DEBUG_UART_BAUD;
  localparam int DEF_IDLE_BITS     = 12;
  localparam int DEF_TIMEOUT_BITS  = 1024;

  typedef enum logic [1:0] {
    S_CPU,
    S_DRAIN_TO_OCD,
    S_OCD,
    S_DRAIN_TO_CPU
  } arb_state_e;

  function automatic logic is_drain(arb_state_e s);
    return (s == S_DRAIN_TO_OCD) || (s == S_DRAIN_TO_CPU);
  endfunction

endpackage

// File: rtl/uart_bit_tick.sv
// rtl/uart_bit_tick.sv - bit-period prescaler; tick_o pulses one cycle every
// BAUD_PERIOD clocks while clear_i is low.
module uart_bit_tick #(
  parameter int BAUD_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = $clog2(BAUD_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BAUD_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/debug_uart_tx_arbiter.sv
// rtl/debug_uart_tx_arbiter.sv - hands the debug UART pin between CPU and OCD,
// waiting for the old talker to go idle (or time out) before switching.
module debug_uart_tx_arbiter
  import debug_uart_tx_arbiter_pkg::*;
#(
  parameter int BAUD_PERIOD  = DEF_BAUD_PERIOD,
  parameter int IDLE_BITS    = DEF_IDLE_BITS,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sel_ocd1_cpu0,
  input  logic tx_cpu,
  input  logic tx_ocd,
  output logic TXD,
  output logic active_ocd,
  output logic switch_pending
);

  localparam int IW = $clog2(IDLE_BITS) + 1;
  localparam int TW = $clog2(TIMEOUT_BITS) + 1;
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_BITS);
  localparam logic [TW-1:0] TOUT_LIM = TW'(TIMEOUT_BITS);

  arb_state_e    state_q, state_d;
  logic          sel_q, cpu_q, ocd_q, txd_q;
  logic [IW-1:0] idle_q, idle_d, idle_nxt;
  logic [TW-1:0] tout_q, tout_d, tout_nxt;
  logic          old_line, bit_tick, done;

  uart_bit_tick #(.BAUD_PERIOD(BAUD_PERIOD)) u_bit_tick (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clear_i(!is_drain(state_q)),
    .tick_o (bit_tick)
  );

  // The old owner keeps the pin through the whole drain.
  assign old_line = (state_q == S_CPU || state_q == S_DRAIN_TO_OCD) ? cpu_q : ocd_q;
  assign done     = (idle_q == IDLE_LIM) || (tout_q == TOUT_LIM);

  always_comb begin
    idle_nxt = idle_q;
    if (!old_line) begin
      idle_nxt = '0;
    end else if (bit_tick && (idle_q != IDLE_LIM)) begin
      idle_nxt = idle_q + 1'b1;
    end
    tout_nxt = tout_q;
    if (bit_tick && (tout_q != TOUT_LIM)) begin
      tout_nxt = tout_q + 1'b1;
    end
  end

  // Counters only survive while staying in the same drain; abort is checked first.
  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    tout_d  = '0;
    case (state_q)
      S_CPU: if (sel_q) state_d = S_DRAIN_TO_OCD;
      S_OCD: if (!sel_q) state_d = S_DRAIN_TO_CPU;
      S_DRAIN_TO_OCD: begin
        if (!sel_q) begin
          state_d = S_CPU;
        end else if (done) begin
          state_d = S_OCD;
        end else begin
          idle_d = idle_nxt;
          tout_d = tout_nxt;
        end
      end
      S_DRAIN_TO_CPU: begin
        if (sel_q) begin
          state_d = S_OCD;
        end else if (done) begin
          state_d = S_CPU;
        end else begin
          idle_d = idle_nxt;
          tout_d = tout_nxt;
        end
      end
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CPU;
      sel_q   <= 1'b0;
      cpu_q   <= 1'b1;
      ocd_q   <= 1'b1;
      txd_q   <= 1'b1;
      idle_q  <= '0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_ocd1_cpu0;
      cpu_q   <= tx_cpu;
      ocd_q   <= tx_ocd;
      txd_q   <= old_line;
      idle_q  <= idle_d;
      tout_q  <= tout_d;
    end
  end

  assign TXD            = txd_q;
  assign active_ocd     = (state_q == S_OCD) || (state_q == S_DRAIN_TO_CPU);
  assign switch_pending = is_drain(state_q);

endmodule
